// File: rtl/multicycle_controller_v2_if.sv
// Bundle between the multicycle controller and its IR/comparator/memory/datapath neighbours.
// The controller attaches through the slave modport; whatever drives the IR side uses master.
interface multicycle_controller_v2_if #(
  parameter int CNT_WIDTH = 32
);
  // Handshake: imem_req/DMemRead/DMemWrite are level-held requests. A request
  // completes in the cycle where it is high and the matching *_ready is high.
  // A ready seen while no request is pending is ignored.
  logic [6:0]           opCode;
  logic [2:0]           funct3;
  logic                 branch;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 imem_req;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 DMemRead;
  logic                 DMemWrite;
  logic                 ALUOverride;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic                 regFileWrite;
  logic                 regFileWriteSrc;
  logic                 trap;
  logic [1:0]           trap_cause;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    output opCode, funct3, branch, imem_ready, dmem_ready,
    input  imem_req, IRWrite, PCWrite, DMemRead, DMemWrite, ALUOverride,
           ALUSrcA, ALUSrcB, regFileWrite, regFileWriteSrc, trap, trap_cause, instret
  );

  modport slave (
    input  opCode, funct3, branch, imem_ready, dmem_ready,
    output imem_req, IRWrite, PCWrite, DMemRead, DMemWrite, ALUOverride,
           ALUSrcA, ALUSrcB, regFileWrite, regFileWriteSrc, trap, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_controller_v2.sv
// Multicycle RV32I main controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing with
// variable-latency memory handshakes, memory timeouts, illegal-op detection and a sticky TRAP.
module multicycle_controller_v2 #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int TMO_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  multicycle_controller_v2_if.slave    bus,
  output logic [2:0]                   dbg_state
);

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;

  localparam logic [1:0] A_REG   = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_ZERO  = 2'd2;
  localparam logic [1:0] B_REG   = 2'd0;
  localparam logic [1:0] B_IMM   = 2'd1;
  localparam logic [1:0] B_FOUR  = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t               state_q;
  logic [TMO_WIDTH-1:0] wait_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 trap_q;
  logic [1:0]           cause_q;
  logic                 legal;
  logic                 is_mem;
  logic                 tmo_hit;

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_ALU_REG, OP_ALU_IMM, OP_LUI, OP_AUIPC, OP_JAL: is_legal = 1'b1;
      OP_JALR:   is_legal = (f3 == 3'd0);
      OP_BRANCH: is_legal = (f3 != 3'd2) && (f3 != 3'd3);
      OP_LOAD:   is_legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      OP_STORE:  is_legal = (f3 <= 3'd2);
      default:   is_legal = 1'b0;
    endcase
  endfunction

  assign legal     = is_legal(bus.opCode, bus.funct3);
  assign is_mem    = (bus.opCode == OP_LOAD) || (bus.opCode == OP_STORE);
  // A zero MEM_TIMEOUT means wait forever.
  assign tmo_hit   = (MEM_TIMEOUT != 0) && (wait_q == TMO_WIDTH'(MEM_TIMEOUT - 1));
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready) begin
            state_q <= S_DECODE;
            wait_q  <= '0;
          end else if (tmo_hit) begin
            state_q <= S_TRAP;
            wait_q  <= '0;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_IMEM;
          end else begin
            wait_q  <= wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          wait_q <= '0;
          if (legal) begin
            state_q <= S_EXECUTE;
          end else begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end
        end
        S_EXECUTE: begin
          state_q <= S_MEMORY;
          wait_q  <= '0;
        end
        S_MEMORY: begin
          if (!is_mem || bus.dmem_ready) begin
            state_q <= S_WRITEBACK;
            wait_q  <= '0;
          end else if (tmo_hit) begin
            state_q <= S_TRAP;
            wait_q  <= '0;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_DMEM;
          end else begin
            wait_q  <= wait_q + 1'b1;
          end
        end
        S_WRITEBACK: begin
          state_q   <= S_FETCH;
          wait_q    <= '0;
          instret_q <= instret_q + 1'b1;
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          state_q <= S_FETCH;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // Strobes and selects are decoded from the current state; reset masks every output.
  always_comb begin
    bus.imem_req        = 1'b0;
    bus.IRWrite         = 1'b0;
    bus.PCWrite         = 1'b0;
    bus.DMemRead        = 1'b0;
    bus.DMemWrite       = 1'b0;
    bus.ALUOverride     = 1'b0;
    bus.ALUSrcA         = A_REG;
    bus.ALUSrcB         = B_REG;
    bus.regFileWrite    = 1'b0;
    bus.regFileWriteSrc = 1'b0;
    bus.trap            = rst_n & trap_q;
    bus.trap_cause      = rst_n ? cause_q : 2'd0;
    bus.instret         = rst_n ? instret_q : '0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.IRWrite  = bus.imem_ready;
        end
        S_EXECUTE: begin
          case (bus.opCode)
            OP_ALU_REG, OP_BRANCH: begin bus.ALUSrcA = A_REG;  bus.ALUSrcB = B_REG;  end
            OP_JAL, OP_JALR:       begin bus.ALUSrcA = A_PC;   bus.ALUSrcB = B_FOUR; end
            OP_LUI:                begin bus.ALUSrcA = A_ZERO; bus.ALUSrcB = B_IMM;  end
            OP_AUIPC:              begin bus.ALUSrcA = A_PC;   bus.ALUSrcB = B_IMM;  end
            default:               begin bus.ALUSrcA = A_REG;  bus.ALUSrcB = B_IMM;  end
          endcase
        end
        S_MEMORY: begin
          // The ALU is borrowed here for the next-PC sum.
          bus.ALUOverride = 1'b1;
          bus.DMemRead    = (bus.opCode == OP_LOAD);
          bus.DMemWrite   = (bus.opCode == OP_STORE);
          case (bus.opCode)
            OP_JALR:   begin bus.ALUSrcA = A_REG; bus.ALUSrcB = B_IMM; end
            OP_JAL:    begin bus.ALUSrcA = A_PC;  bus.ALUSrcB = B_IMM; end
            OP_BRANCH: begin bus.ALUSrcA = A_PC;  bus.ALUSrcB = bus.branch ? B_IMM : B_FOUR; end
            default:   begin bus.ALUSrcA = A_PC;  bus.ALUSrcB = B_FOUR; end
          endcase
        end
        S_WRITEBACK: begin
          bus.PCWrite         = 1'b1;
          bus.regFileWrite    = (bus.opCode != OP_STORE) && (bus.opCode != OP_BRANCH);
          bus.regFileWriteSrc = (bus.opCode == OP_LOAD);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller_v2.sv
// Randomised bench for multicycle_controller_v2: a phase-level instruction model fills
// stimulus/expected queues, and each scenario task replays and compares them cycle by cycle.
module tb_multicycle_controller_v2;

  localparam int TMO = 16;
  localparam int W   = 19;

  localparam logic [6:0] OPC_ADD    = 7'b0110011;
  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  multicycle_controller_v2_if #(.CNT_WIDTH(4)) bus();

  multicycle_controller_v2 #(
    .MEM_TIMEOUT(TMO),
    .CNT_WIDTH  (4),
    .TMO_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [12:0]   stim_q[$];
  logic [3:0]    m_cnt;
  logic [1:0]    m_cause;
  int            n_checks;
  int            n_pass;

  // ---------------- reference model ----------------
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OPC_ADD, OPC_ADDI, OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b1;
      OPC_JALR:   return f3 == 3'd0;
      OPC_BRANCH: return !(f3 inside {3'd2, 3'd3});
      OPC_LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      OPC_STORE:  return f3 inside {3'd0, 3'd1, 3'd2};
      default:    return 1'b0;
    endcase
  endfunction

  // {ALUSrcA, ALUSrcB} for the operand computation
  function automatic logic [3:0] exec_sel(input logic [6:0] op);
    case (op)
      OPC_ADD, OPC_BRANCH: return {2'd0, 2'd0};
      OPC_JAL, OPC_JALR:   return {2'd1, 2'd2};
      OPC_LUI:             return {2'd2, 2'd1};
      OPC_AUIPC:           return {2'd1, 2'd1};
      default:             return {2'd0, 2'd1};
    endcase
  endfunction

  // {ALUSrcA, ALUSrcB} for the next-PC computation
  function automatic logic [3:0] pc_sel(input logic [6:0] op, input logic br);
    case (op)
      OPC_JALR:   return {2'd0, 2'd1};
      OPC_JAL:    return {2'd1, 2'd1};
      OPC_BRANCH: return br ? {2'd1, 2'd1} : {2'd1, 2'd2};
      default:    return {2'd1, 2'd2};
    endcase
  endfunction

  function automatic logic [W-1:0] pack(
    input logic req, irw, pcw, rd, wr, ovr,
    input logic [1:0] a, b,
    input logic rfw, src, trp,
    input logic [1:0] cause,
    input logic [3:0] cnt
  );
    return {req, irw, pcw, rd, wr, ovr, a, b, rfw, src, trp, cause, cnt};
  endfunction

  function automatic logic [W-1:0] observe();
    return {bus.imem_req, bus.IRWrite, bus.PCWrite, bus.DMemRead, bus.DMemWrite,
            bus.ALUOverride, bus.ALUSrcA, bus.ALUSrcB, bus.regFileWrite,
            bus.regFileWriteSrc, bus.trap, bus.trap_cause, bus.instret};
  endfunction

  // Queue one instruction: iwait/dwait idle cycles before the matching ready.
  task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                           input int iwait, input int dwait);
    logic [3:0] sel;
    logic       is_ld, is_st, mem_op, rdy;
    int         n;
    is_ld  = (op == OPC_LOAD);
    is_st  = (op == OPC_STORE);
    mem_op = is_ld | is_st;
    for (int k = 0; k <= iwait && k < TMO; k++) begin
      rdy = (k == iwait);
      stim_q.push_back({op, f3, rdy, rbit(), br});
      exp_q.push_back(pack(1'b1, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                           1'b0, 1'b0, 1'b0, 2'd0, m_cnt));
    end
    if (iwait >= TMO) begin
      m_cause = 2'd2;
      return;
    end
    stim_q.push_back({op, f3, rbit(), rbit(), br});
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                         1'b0, 1'b0, 1'b0, 2'd0, m_cnt));
    if (!legal(op, f3)) begin
      m_cause = 2'd1;
      return;
    end
    sel = exec_sel(op);
    stim_q.push_back({op, f3, rbit(), rbit(), br});
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sel[3:2], sel[1:0],
                         1'b0, 1'b0, 1'b0, 2'd0, m_cnt));
    n   = mem_op ? dwait : 0;
    sel = pc_sel(op, br);
    for (int k = 0; k <= n && k < TMO; k++) begin
      rdy = mem_op ? (k == dwait) : rbit();
      stim_q.push_back({op, f3, rbit(), rdy, br});
      exp_q.push_back(pack(1'b0, 1'b0, 1'b0, is_ld, is_st, 1'b1, sel[3:2], sel[1:0],
                           1'b0, 1'b0, 1'b0, 2'd0, m_cnt));
    end
    if (mem_op && dwait >= TMO) begin
      m_cause = 2'd3;
      return;
    end
    stim_q.push_back({op, f3, rbit(), rbit(), br});
    exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                         !(is_st || op == OPC_BRANCH), is_ld, 1'b0, 2'd0, m_cnt));
    m_cnt = m_cnt + 4'd1;
  endtask

  task automatic gen_trap(input int n);
    for (int k = 0; k < n; k++) begin
      stim_q.push_back({7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                        rbit(), rbit(), rbit()});
      exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                           1'b0, 1'b0, 1'b1, m_cause, m_cnt));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [12:0] s);
    {bus.opCode, bus.funct3, bus.imem_ready, bus.dmem_ready, bus.branch} = s;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    m_cnt   = 4'd0;
    m_cause = 2'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] got;
    for (int k = 0; k < 2; k++) begin
      rst_n = 1'b0;
      drive({7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b1, rbit(), rbit()});
      got = observe();
      n_checks++;
      if (got !== '0) $display("FAIL reset cyc %0d: got %h expected %h", k, got, {W{1'b0}});
      else n_pass++;
      tick();
    end
    rst_n   = 1'b1;
    m_cnt   = 4'd0;
    m_cause = 2'd0;
  endtask

  task automatic test_add();
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    idx = 0;
    gen_instr(OPC_ADD, 3'($urandom_range(0, 7)), rbit(), 0, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL add cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
    n_checks++;
    if (bus.instret !== m_cnt) $display("FAIL add_instret: got %0d expected %0d", bus.instret, m_cnt);
    else n_pass++;
  endtask

  task automatic test_load_wait();
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    idx = 0;
    gen_instr(OPC_LOAD, 3'd2, 1'b0, 0, 3);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL load_wait cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
    n_checks++;
    if (idx !== 8) $display("FAIL load_len: got %0d expected 8", idx);
    else n_pass++;
  endtask

  task automatic test_branch();
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    idx = 0;
    gen_instr(OPC_BRANCH, 3'd0, 1'b1, $urandom_range(0, 2), 0);
    gen_instr(OPC_BRANCH, 3'd1, 1'b0, $urandom_range(0, 2), 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL branch cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
  endtask

  task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3);
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    idx = 0;
    gen_instr(op, f3, rbit(), 1, 0);
    gen_trap(20);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL illegal_%h_%0d cyc %0d: got %h expected %h", op, f3, idx, got, e);
      else n_pass++;
      idx++; tick();
    end
  endtask

  task automatic test_imem_timeout();
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    idx = 0;
    gen_instr(OPC_ADD, 3'd0, 1'b0, TMO, 0);
    gen_trap(4);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL imem_timeout cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
    apply_reset();
    idx = 0;
    gen_instr(OPC_ADDI, 3'd0, 1'b0, TMO - 1, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL imem_late_ready cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
  endtask

  task automatic test_dmem_timeout();
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    idx = 0;
    gen_instr(OPC_STORE, 3'd2, 1'b0, 0, TMO - 1);
    gen_instr(OPC_LOAD, 3'd0, 1'b0, 0, TMO);
    gen_trap(4);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL dmem_timeout cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops[9] = '{OPC_ADD, OPC_ADDI, OPC_LUI, OPC_AUIPC, OPC_JAL,
                            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE};
    logic [6:0]  op; logic [2:0] f3;
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    idx = 0;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 8)];
      do f3 = 3'($urandom_range(0, 7)); while (!legal(op, f3));
      gen_instr(op, f3, rbit(), $urandom_range(0, 4), $urandom_range(0, 4));
    end
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL random cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
  endtask

  task automatic test_instret_wrap();
    logic [12:0] s; logic [W-1:0] e, got; int idx;
    apply_reset();
    idx = 0;
    for (int i = 0; i < 15; i++) gen_instr(OPC_ADD, 3'd0, 1'b0, 0, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL wrap_fill cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
    n_checks++;
    if (bus.instret !== 4'd15) $display("FAIL instret_full: got %0d expected 15", bus.instret);
    else n_pass++;
    gen_instr(OPC_LUI, 3'd0, 1'b0, 0, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s); got = observe();
      n_checks++;
      if (got !== e) $display("FAIL wrap_last cyc %0d: got %h expected %h", idx, got, e);
      else n_pass++;
      idx++; tick();
    end
    n_checks++;
    if (bus.instret !== 4'd0) $display("FAIL instret_wrap: got %0d expected 0", bus.instret);
    else n_pass++;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_cnt    = 4'd0;
    m_cause  = 2'd0;
    rst_n    = 1'b0;
    {bus.opCode, bus.funct3, bus.imem_ready, bus.dmem_ready, bus.branch} = '0;
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_illegal(7'b1111111, 3'($urandom_range(0, 7)));
    test_reset();
    test_illegal(OPC_JALR, 3'd3);
    test_reset();
    test_imem_timeout();
    test_reset();
    test_dmem_timeout();
    test_reset();
    test_random();
    test_instret_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller_v2.md
Name: multicycle_controller_v2

Overview:
- Parametrised successor to the single-issue multicycle main controller. Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for RV32I opcodes.
- Adds over the previous generation:
  - variable-latency instruction and data memory handshakes, with a timeout
  - illegal opcode/funct3 detection, with a sticky TRAP state
  - LUI/AUIPC support through a zero ALU-A source
  - retired-instruction counter
- Sits between the IR/branch comparator and the datapath select/enable signals.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting on imem_ready/dmem_ready before trapping; 0 disables the timeout.
- CNT_WIDTH, 32, width of the instret counter.
- TMO_WIDTH, 8, width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opCode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- branch  in  1  branch-taken flag from the comparator, valid in MEMORY.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access completes this cycle.
- imem_req  out  1  instruction fetch request.
- IRWrite  out  1  latch IR.
- PCWrite  out  1  latch PC.
- DMemRead  out  1  data read request.
- DMemWrite  out  1  data write request.
- ALUOverride  out  1  force ALU add for next-PC computation.
- ALUSrcA  out  2  0=REGOUT, 1=PC, 2=ZERO.
- ALUSrcB  out  2  0=REGOUT, 1=IMMED, 2=CONST4.
- regFileWrite  out  1  register file write enable.
- regFileWriteSrc  out  1  0=EX, 1=MEM.
- trap  out  1  sticky fault indicator.
- trap_cause  out  2  1=illegal, 2=imem timeout, 3=dmem timeout.
- instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Clocking and reset:
  - One clock. Synchronous active-low reset: clk, rst_n.
  - rst_n=0 at a rising edge: state=FETCH, wait counter=0, instret=0, trap=0, trap_cause=0.
  - While rst_n=0, all outputs are forced to 0, including imem_req.
  - Reset taken mid-instruction or in TRAP aborts to FETCH with no PCWrite.
- Output decoding:
  - Outputs are decoded combinationally from state, opCode and branch. Every output is assigned in every state; no latches.
  - Defaults: all strobes 0, ALUSrcA=0, ALUSrcB=0, regFileWriteSrc=0.
- FETCH:
  - imem_req=1.
  - imem_ready=1: IRWrite=1, next state DECODE.
  - imem_ready=0: stay in FETCH, wait counter increments.
  - Counter reaches MEM_TIMEOUT-1 with no ready: next state TRAP, cause=2.
  - Ready in the same cycle as the timeout wins.
- DECODE, legal set:
  - ALU_REG 0110011, ALU_IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111.
  - JALR 1100111 with funct3=0.
  - BRANCH 1100011 with funct3 not in {2,3}.
  - LOAD 0000011 with funct3 in {0,1,2,4,5}.
  - STORE 0100011 with funct3 in {0,1,2}.
  - Anything else: next state TRAP, cause=1. Otherwise next state EXECUTE.
- EXECUTE (ALU selects A/B):
  - ALU_REG: REGOUT/REGOUT.
  - BRANCH: REGOUT/REGOUT.
  - JAL, JALR: PC/CONST4.
  - LUI: ZERO/IMMED.
  - AUIPC: PC/IMMED.
  - Others: REGOUT/IMMED.
  - Next state MEMORY.
- MEMORY (ALUOverride=1, next-PC selects):
  - JALR: REGOUT/IMMED.
  - JAL: PC/IMMED.
  - BRANCH: PC with IMMED if branch, else CONST4.
  - Others: PC/CONST4.
  - LOAD asserts DMemRead; STORE asserts DMemWrite. The request is level-held, with selects held, until dmem_ready=1; then next state WRITEBACK.
  - Timeout is handled as in FETCH, with cause=3.
  - Non-memory ops leave in one cycle regardless of dmem_ready.
- WRITEBACK:
  - PCWrite=1.
  - regFileWrite=0 for STORE and BRANCH, 1 otherwise.
  - regFileWriteSrc=MEM for LOAD, EX otherwise.
  - instret increments, wrapping modulo 2^CNT_WIDTH.
  - Next state FETCH.
- Wait counter: cleared on every state change.
- TRAP: absorbing until reset. trap=1, trap_cause held, all strobes 0, instret frozen.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release with imem_ready=1.
  -> All outputs 0 during reset; FETCH shows imem_req=1, IRWrite=1.
- ADD (0110011) with both readies tied high.
  -> Exactly 5 cycles.
  -> EXECUTE A=0, B=0.
  -> WRITEBACK PCWrite=1, regFileWrite=1, src=0.
  -> instret 0->1.
- LW (0000011, f3=2) with dmem_ready low 3 cycles.
  -> DMemRead=1 for 4 cycles in MEMORY.
  -> WRITEBACK src=1.
  -> Total 8 cycles.
- BEQ with branch=1, then BNE with branch=0.
  -> MEMORY B=1, then B=2.
  -> Both give regFileWrite=0, PCWrite=1.
- Illegal opCode 1111111, then JALR with funct3=3.
  -> trap=1, cause=1 one cycle after DECODE.
  -> Stays in TRAP for 20 cycles until rst_n=0.
- imem_ready held 0 with MEM_TIMEOUT=16.
  -> trap, cause=2 after 16 FETCH cycles.
  -> Repeat with ready arriving in cycle 16: no trap, DECODE entered.
- instret at all-ones (CNT_WIDTH=4, value 15) plus one retire.
  -> Wraps to 0.
